// File: rtl/fpu_addsub_seq.sv
// Bus-mapped multi-cycle floating-point add/subtract engine (align -> add -> iterative normalise).
module fpu_addsub_seq #(
  parameter int unsigned EXP_W  = 8,
  parameter int unsigned MAN_W  = 23,
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic [7:0]        databus_in,
  output logic [7:0]        databus_out,
  input  logic [ADDR_W-1:0] addr,
  input  logic              cs,
  input  logic              rd,
  input  logic              wr,
  input  logic              end_ack,
  output logic              cmd_end,
  output logic              busy
);

  localparam int unsigned W      = 1 + EXP_W + MAN_W;
  localparam int unsigned NB     = (W + 7) / 8;
  localparam int unsigned WP     = NB * 8;
  localparam int unsigned SH_MAX = MAN_W + 1;

  localparam logic [WP-1:0]     PAD_MASK = WP'({W{1'b1}});
  localparam logic [EXP_W-1:0]  EXP_ONES = '1;
  localparam logic [W-1:0]      QNAN     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic [ADDR_W-1:0] A_OP     = ADDR_W'(16);
  localparam logic [ADDR_W-1:0] A_STAT   = ADDR_W'(17);

  typedef enum logic [1:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM} state_t;

  state_t              r_state, w_state_nxt;
  logic [WP-1:0]       r_a, r_b;
  logic [7:0]          r_op;
  logic [W-1:0]        r_result;
  logic                r_busy, r_cmd_end;
  logic                r_ovf, r_unf, r_inv, r_badop;
  logic                r_op_wr_q;
  logic                r_sign, r_eff_sub;
  logic [EXP_W-1:0]    r_exp;
  logic [MAN_W:0]      r_mbig, r_msml, r_man;

  logic                w_wr, w_op_wr, w_start, w_badop, w_special;
  logic [EXP_W-1:0]    w_ea, w_eb, w_e_big, w_e_small, w_ediff, w_exp_inc, w_exp_dec;
  logic [MAN_W:0]      w_ma, w_mb, w_m_big, w_m_small, w_m_shift;
  logic                w_sa, w_sb, w_a_big;
  logic [MAN_W+1:0]    w_sum;
  logic                w_carry;
  logic                w_fin, w_set_ovf, w_set_unf, w_set_inv, w_set_bad;
  logic [W-1:0]        w_fin_res;
  logic [WP-1:0]       w_res_pad;
  logic [7:0]          w_status, w_rd_data;

  // Bus decode and operation start (edge-detected OP write while idle)
  assign w_wr      = !cs && !wr;
  assign w_op_wr   = w_wr && (addr == A_OP);
  assign w_start   = w_op_wr && !r_op_wr_q && (r_state == S_IDLE);
  assign w_badop   = databus_in[3:0] > 4'd1;

  // Operand unpack; exponent zero flushes the operand to zero
  assign w_ea      = r_a[W-2 -: EXP_W];
  assign w_eb      = r_b[W-2 -: EXP_W];
  assign w_ma      = (w_ea == '0) ? '0 : {1'b1, r_a[MAN_W-1:0]};
  assign w_mb      = (w_eb == '0) ? '0 : {1'b1, r_b[MAN_W-1:0]};
  assign w_sa      = r_a[W-1];
  assign w_sb      = r_b[W-1] ^ r_op[0];
  assign w_special = (w_ea == EXP_ONES) || (w_eb == EXP_ONES);

  // Alignment: larger magnitude by (exp, mantissa), smaller shifted right and truncated
  assign w_a_big   = {w_ea, w_ma} >= {w_eb, w_mb};
  assign w_e_big   = w_a_big ? w_ea : w_eb;
  assign w_e_small = w_a_big ? w_eb : w_ea;
  assign w_m_big   = w_a_big ? w_ma : w_mb;
  assign w_m_small = w_a_big ? w_mb : w_ma;
  assign w_ediff   = w_e_big - w_e_small;
  assign w_m_shift = (32'(w_ediff) > SH_MAX) ? '0 : (w_m_small >> w_ediff);

  // Mantissa sum/difference; the larger operand is always the minuend
  assign w_sum     = r_eff_sub ? ({1'b0, r_mbig} - {1'b0, r_msml})
                               : ({1'b0, r_mbig} + {1'b0, r_msml});
  assign w_carry   = w_sum[MAN_W+1];
  assign w_exp_inc = r_exp + EXP_W'(1);
  assign w_exp_dec = r_exp - EXP_W'(1);

  // FSM state register
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // FSM next state and finish result selection
  always_comb begin
    w_state_nxt = r_state;
    w_fin       = 1'b0;
    w_fin_res   = r_result;
    w_set_ovf   = 1'b0;
    w_set_unf   = 1'b0;
    w_set_inv   = 1'b0;
    w_set_bad   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          if (w_badop) begin
            w_fin     = 1'b1;
            w_set_bad = 1'b1;
          end else if (w_special) begin
            w_fin     = 1'b1;
            w_set_inv = 1'b1;
            w_fin_res = QNAN;
          end else begin
            w_state_nxt = S_ALIGN;
          end
        end
      end
      S_ALIGN: w_state_nxt = S_ADD;
      S_ADD: begin
        if (w_sum == '0) begin
          w_fin     = 1'b1;
          w_fin_res = '0;
        end else if (w_carry && (w_exp_inc == EXP_ONES)) begin
          w_fin     = 1'b1;
          w_set_ovf = 1'b1;
          w_fin_res = {r_sign, EXP_ONES, {MAN_W{1'b0}}};
        end else begin
          w_state_nxt = S_NORM;
        end
      end
      S_NORM: begin
        if (r_man[MAN_W]) begin
          w_fin     = 1'b1;
          w_fin_res = {r_sign, r_exp, r_man[MAN_W-1:0]};
        end else if (r_exp == EXP_W'(1)) begin
          w_fin     = 1'b1;
          w_set_unf = 1'b1;
          w_fin_res = {r_sign, {(W-1){1'b0}}};
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_fin) w_state_nxt = S_IDLE;
  end

  // Operand/opcode registers, writable only while idle
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_a       <= '0;
      r_b       <= '0;
      r_op      <= '0;
      r_op_wr_q <= 1'b0;
    end else begin
      r_op_wr_q <= w_op_wr;
      if (w_wr && !r_busy) begin
        for (int i = 0; i < int'(NB); i++) begin
          if (addr == ADDR_W'(i))     r_a[i*8 +: 8] <= databus_in & PAD_MASK[i*8 +: 8];
          if (addr == ADDR_W'(8 + i)) r_b[i*8 +: 8] <= databus_in & PAD_MASK[i*8 +: 8];
        end
        if (addr == A_OP) r_op <= databus_in;
      end
    end
  end

  // Datapath registers for align, add and normalise steps
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_sign    <= 1'b0;
      r_eff_sub <= 1'b0;
      r_exp     <= '0;
      r_mbig    <= '0;
      r_msml    <= '0;
      r_man     <= '0;
    end else begin
      case (r_state)
        S_ALIGN: begin
          r_sign    <= w_a_big ? w_sa : w_sb;
          r_eff_sub <= w_sa ^ w_sb;
          r_exp     <= w_e_big;
          r_mbig    <= w_m_big;
          r_msml    <= w_m_shift;
        end
        S_ADD: begin
          if (w_carry) begin
            r_man <= w_sum[MAN_W+1:1];
            r_exp <= w_exp_inc;
          end else begin
            r_man <= w_sum[MAN_W:0];
          end
        end
        S_NORM: begin
          if (!r_man[MAN_W]) begin
            r_man <= {r_man[MAN_W-1:0], 1'b0};
            r_exp <= w_exp_dec;
          end
        end
        default: ;
      endcase
    end
  end

  // Result, handshake and sticky status flags
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_result  <= '0;
      r_busy    <= 1'b0;
      r_cmd_end <= 1'b0;
      r_ovf     <= 1'b0;
      r_unf     <= 1'b0;
      r_inv     <= 1'b0;
      r_badop   <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt != S_IDLE);
      if (w_fin) r_result <= w_fin_res;
      if (w_fin)                    r_cmd_end <= 1'b1;
      else if (w_start || end_ack)  r_cmd_end <= 1'b0;
      if (w_start) begin
        r_ovf   <= 1'b0;
        r_unf   <= 1'b0;
        r_inv   <= w_set_inv;
        r_badop <= w_set_bad;
      end else begin
        if (w_set_ovf) r_ovf <= 1'b1;
        if (w_set_unf) r_unf <= 1'b1;
      end
    end
  end

  assign w_res_pad = WP'(r_result);
  assign w_status  = {2'b00, r_badop, r_inv, r_unf, r_ovf, r_cmd_end, r_busy};

  // Read mux; unmapped addresses return zero
  always_comb begin
    w_rd_data = '0;
    for (int i = 0; i < int'(NB); i++) begin
      if (addr == ADDR_W'(i))      w_rd_data = r_a[i*8 +: 8];
      if (addr == ADDR_W'(8 + i))  w_rd_data = r_b[i*8 +: 8];
      if (addr == ADDR_W'(24 + i)) w_rd_data = w_res_pad[i*8 +: 8];
    end
    if (addr == A_OP)   w_rd_data = r_op;
    if (addr == A_STAT) w_rd_data = w_status;
  end

  assign databus_out = (!cs && !rd) ? w_rd_data : 8'hzz;
  assign busy        = r_busy;
  assign cmd_end     = r_cmd_end;

endmodule
